// File: rtl/cap_array_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// cap_array_cfg_ctrl: resets and programs the Giraffe cap-array coefficient
// registers from a local table; readback verify when CAP_CFG_VERIFY_EN is set.
// Rev 1.0
// ============================================================================
module cap_array_cfg_ctrl #(
  parameter int N_POS      = 32,
  parameter int N_COEF     = 3,
  parameter int RST_CYCLES = 1000,
  parameter int WR_PULSE   = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk_50M,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              tbl_we,
  input  logic [4:0]        tbl_addr,
  input  logic [N_COEF-1:0] tbl_data,
  input  logic              cap_rd_valid,
  input  logic [N_COEF-1:0] cap_coef_out,
  output logic              cap_rstn,
  output logic              cap_wena,
  output logic              cap_rena,
  output logic [4:0]        cap_position,
  output logic [N_COEF-1:0] cap_coefficent_in,
  output logic              cap_read_ack,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [5:0]        mismatch_cnt,
  output logic [4:0]        first_err_pos
);

  localparam int CNT_MAX_W = (RST_CYCLES > WR_PULSE) ? RST_CYCLES : WR_PULSE;
`ifdef CAP_CFG_VERIFY_EN
  localparam int CNT_MAX = (CNT_MAX_W > RD_TIMEOUT) ? CNT_MAX_W : RD_TIMEOUT;
`else
  localparam int CNT_MAX = CNT_MAX_W;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WR_LAST  = CNT_W'(WR_PULSE - 1);
  localparam logic [5:0]       C_NPOS     = 6'(N_POS);
  localparam logic [4:0]       C_LAST     = 5'(N_POS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WSETUP = 3'd2,
    S_WPULSE = 3'd3,
    S_WHOLD  = 3'd4,
    S_RREQ   = 3'd5,
    S_RACK   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t            r_state;
  logic [N_COEF-1:0] r_tbl [N_POS];
  logic [4:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        w_idx_nxt;

  assign w_idx_nxt = r_idx + 5'd1;

  // Host table; frozen for the whole run so written data matches what is verified
  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_POS; i++) r_tbl[i] <= '0;
    end else if (tbl_we && !busy && ({1'b0, tbl_addr} < C_NPOS)) begin
      r_tbl[tbl_addr] <= tbl_data;
    end
  end

`ifdef CAP_CFG_VERIFY_EN
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(RD_TIMEOUT - 1);
  logic              r_err_seen;
  logic [N_COEF-1:0] r_rd_data;
`else
  logic w_unused;
  assign w_unused      = ^{cap_rd_valid, cap_coef_out};
  assign cap_rena      = 1'b0;
  assign cap_read_ack  = 1'b0;
  assign err_timeout   = 1'b0;
  assign mismatch_cnt  = 6'd0;
  assign first_err_pos = 5'd0;
`endif

  always_ff @(posedge clk_50M or negedge nrst) begin
    if (!nrst) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_cnt             <= '0;
      cap_rstn          <= 1'b1;
      cap_wena          <= 1'b0;
      cap_position      <= '0;
      cap_coefficent_in <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
`ifdef CAP_CFG_VERIFY_EN
      cap_rena          <= 1'b0;
      cap_read_ack      <= 1'b0;
      err_timeout       <= 1'b0;
      mismatch_cnt      <= '0;
      first_err_pos     <= '0;
      r_err_seen        <= 1'b0;
      r_rd_data         <= '0;
`endif
    end else if (abort && (r_state != S_IDLE)) begin
      // Error status is deliberately left with whatever was gathered so far
      r_state           <= S_IDLE;
      cap_rstn          <= 1'b1;
      cap_wena          <= 1'b0;
      cap_position      <= '0;
      cap_coefficent_in <= '0;
      busy              <= 1'b0;
`ifdef CAP_CFG_VERIFY_EN
      cap_rena          <= 1'b0;
      cap_read_ack      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state  <= S_RESET;
            r_cnt    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            cap_rstn <= 1'b0;
`ifdef CAP_CFG_VERIFY_EN
            err_timeout   <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_pos <= '0;
            r_err_seen    <= 1'b0;
`endif
          end
        end
        S_RESET: begin
          if (r_cnt == C_RST_LAST) begin
            r_state           <= S_WSETUP;
            r_idx             <= '0;
            cap_rstn          <= 1'b1;
            cap_position      <= '0;
            cap_coefficent_in <= r_tbl[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WSETUP: begin
          r_state  <= S_WPULSE;
          r_cnt    <= '0;
          cap_wena <= 1'b1;
        end
        S_WPULSE: begin
          if (r_cnt == C_WR_LAST) begin
            r_state  <= S_WHOLD;
            cap_wena <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WHOLD: begin
          if (r_idx == C_LAST) begin
`ifdef CAP_CFG_VERIFY_EN
            r_state      <= S_RREQ;
            r_idx        <= '0;
            r_cnt        <= '0;
            cap_position <= '0;
            cap_rena     <= 1'b1;
`else
            r_state <= S_DONE;
`endif
          end else begin
            // Position and data are launched here so they are stable for all of WSETUP
            r_state           <= S_WSETUP;
            r_idx             <= w_idx_nxt;
            cap_position      <= w_idx_nxt;
            cap_coefficent_in <= r_tbl[w_idx_nxt];
          end
        end
`ifdef CAP_CFG_VERIFY_EN
        S_RREQ: begin
          if (cap_rd_valid) begin
            r_state      <= S_RACK;
            r_rd_data    <= cap_coef_out;
            cap_rena     <= 1'b0;
            cap_read_ack <= 1'b1;
          end else if (r_cnt == C_TMO_LAST) begin
            r_state     <= S_DONE;
            cap_rena    <= 1'b0;
            err_timeout <= 1'b1;
            if (!r_err_seen) begin
              first_err_pos <= r_idx;
              r_err_seen    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RACK: begin
          cap_read_ack <= 1'b0;
          if (r_rd_data != r_tbl[r_idx]) begin
            if (mismatch_cnt != 6'd63) mismatch_cnt <= mismatch_cnt + 6'd1;
            if (!r_err_seen) begin
              first_err_pos <= r_idx;
              r_err_seen    <= 1'b1;
            end
          end
          if (r_idx == C_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_state      <= S_RREQ;
            r_idx        <= w_idx_nxt;
            r_cnt        <= '0;
            cap_position <= w_idx_nxt;
            cap_rena     <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cap_array_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cap_array_cfg_ctrl: directed bench with a small cap-array chip model.
// Rev 1.0
// ============================================================================
module tb_cap_array_cfg_ctrl;

  localparam int N_POS      = 32;
  localparam int N_COEF     = 3;
  localparam int RST_CYCLES = 10;
  localparam int WR_PULSE   = 4;
  localparam int RD_TIMEOUT = 255;
`ifdef CAP_CFG_VERIFY_EN
  localparam int C_RD_EXTRA = 4 * N_POS;  // RREQ(3, model latency 2) + RACK(1) per position
  localparam int C_ACKS     = N_POS;
`else
  localparam int C_RD_EXTRA = 0;
  localparam int C_ACKS     = 0;
`endif
  localparam int C_RUN_CYC  = RST_CYCLES + N_POS * (WR_PULSE + 2) + 2 + C_RD_EXTRA;
  localparam int C_BOUND    = 3000;

  logic              clk_50M = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              tbl_we = 1'b0;
  logic [4:0]        tbl_addr = '0;
  logic [N_COEF-1:0] tbl_data = '0;
  logic              cap_rd_valid;
  logic [N_COEF-1:0] cap_coef_out;
  logic              cap_rstn, cap_wena, cap_rena, cap_read_ack, busy, done, err_timeout;
  logic [4:0]        cap_position, first_err_pos;
  logic [N_COEF-1:0] cap_coefficent_in;
  logic [5:0]        mismatch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_50M = ~clk_50M;

  cap_array_cfg_ctrl #(
    .N_POS(N_POS), .N_COEF(N_COEF), .RST_CYCLES(RST_CYCLES),
    .WR_PULSE(WR_PULSE), .RD_TIMEOUT(RD_TIMEOUT)
  ) u_dut (
    .clk_50M(clk_50M), .nrst(nrst), .start(start), .abort(abort),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cap_rd_valid(cap_rd_valid), .cap_coef_out(cap_coef_out),
    .cap_rstn(cap_rstn), .cap_wena(cap_wena), .cap_rena(cap_rena),
    .cap_position(cap_position), .cap_coefficent_in(cap_coefficent_in),
    .cap_read_ack(cap_read_ack), .busy(busy), .done(done),
    .err_timeout(err_timeout), .mismatch_cnt(mismatch_cnt), .first_err_pos(first_err_pos)
  );

  // Chip model: echoes m_tbl two cycles after cap_rena rises
  logic [N_COEF-1:0] m_tbl [N_POS];
  int m_lat    = 0;
  int hang_pos = -1;
  int bad_a    = -1;
  int bad_b    = -1;

  always @(posedge clk_50M) m_lat <= cap_rena ? m_lat + 1 : 0;

  always_comb begin
    cap_rd_valid = cap_rena && (m_lat >= 2) && (int'(cap_position) != hang_pos);
    cap_coef_out = m_tbl[cap_position];
    if ((int'(cap_position) == bad_a) || (int'(cap_position) == bad_b))
      cap_coef_out = m_tbl[cap_position] ^ 3'b001;
  end

  // Pin monitor
  int   mon_rst_low, mon_pulses, mon_bad_len, mon_bad_data, mon_wlen, mon_acks, mon_max_rpos;
  logic [N_COEF-1:0] mon_coef [N_POS];
  logic [4:0]        p_pos;
  logic [N_COEF-1:0] p_coef;
  logic              prev_wena = 1'b0;

  always @(negedge clk_50M) begin
    if (!cap_rstn) mon_rst_low++;
    if (cap_wena) begin
      if (!prev_wena) begin
        mon_pulses++;
        mon_wlen = 1;
        mon_coef[cap_position] = cap_coefficent_in;
        if (int'(cap_position) != mon_pulses - 1) mon_bad_data++;
      end else begin
        mon_wlen++;
        if (cap_position != p_pos || cap_coefficent_in != p_coef) mon_bad_data++;
      end
      p_pos  = cap_position;
      p_coef = cap_coefficent_in;
    end else if (prev_wena && mon_wlen != WR_PULSE) begin
      mon_bad_len++;
    end
    if (cap_read_ack) mon_acks++;
    if (cap_rena && int'(cap_position) > mon_max_rpos) mon_max_rpos = int'(cap_position);
    prev_wena = cap_wena;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_rst_low  = 0;
    mon_pulses   = 0;
    mon_bad_len  = 0;
    mon_bad_data = 0;
    mon_acks     = 0;
    mon_max_rpos = -1;
    for (int i = 0; i < N_POS; i++) mon_coef[i] = '0;
  endtask

  // Called and returns at 1 ns after a rising edge; cyc counts edges until done is seen
  task automatic run_cfg(input bit inject, output int cyc);
    clear_mon();
    start = 1'b1;
    @(posedge clk_50M); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < C_BOUND) begin
      if (inject && cyc == 3) begin
        tbl_we = 1'b1; tbl_addr = 5'd3; tbl_data = 3'd7; start = 1'b1;
      end else begin
        tbl_we = 1'b0; start = 1'b0;
      end
      @(posedge clk_50M); #1;
      cyc++;
    end
    tbl_we = 1'b0; start = 1'b0;
    check("run_done_seen", int'(done), 1);
  endtask

  int cyc;
  int coef_err;

  initial begin
    for (int i = 0; i < N_POS; i++) m_tbl[i] = 3'(i % 8);
    clear_mon();

    // Reset state
    repeat (2) @(posedge clk_50M);
    #1;
    check("rst_cap_rstn", int'(cap_rstn), 1);
    check("rst_cap_pins", int'({cap_wena, cap_rena, cap_read_ack, cap_position, cap_coefficent_in}), 0);
    check("rst_status", int'({busy, done, err_timeout, mismatch_cnt, first_err_pos}), 0);
    nrst = 1'b1;
    @(posedge clk_50M); #1;

    for (int i = 0; i < N_POS; i++) begin
      tbl_we = 1'b1; tbl_addr = 5'(i); tbl_data = 3'(i % 8);
      @(posedge clk_50M); #1;
    end
    tbl_we = 1'b0;

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    @(posedge clk_50M); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk_50M); #1;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_rstn", int'(cap_rstn), 1);

    // Full run
    run_cfg(1'b0, cyc);
    check("run1_cycles", cyc, C_RUN_CYC);
    check("run1_rst_low", mon_rst_low, RST_CYCLES);
    check("run1_pulses", mon_pulses, N_POS);
    check("run1_pulse_len", mon_bad_len, 0);
    check("run1_pos_stable", mon_bad_data, 0);
    coef_err = 0;
    for (int i = 0; i < N_POS; i++) if (mon_coef[i] != 3'(i % 8)) coef_err++;
    check("run1_coef_all", coef_err, 0);
    check("run1_coef5", int'(mon_coef[5]), 5);
    check("run1_coef31", int'(mon_coef[31]), 7);
    check("run1_busy", int'(busy), 0);
    check("run1_acks", mon_acks, C_ACKS);
    check("run1_mismatch", int'(mismatch_cnt), 0);
    check("run1_timeout", int'(err_timeout), 0);
    repeat (5) @(posedge clk_50M);
    #1;
    check("run1_done_sticky", int'(done), 1);

`ifdef CAP_CFG_VERIFY_EN
    // Two corrupted readbacks
    bad_a = 5; bad_b = 20;
    run_cfg(1'b0, cyc);
    check("mm_cnt", int'(mismatch_cnt), 2);
    check("mm_first", int'(first_err_pos), 5);
    check("mm_timeout", int'(err_timeout), 0);
    check("mm_acks", mon_acks, N_POS);
    bad_a = -1; bad_b = -1;

    // Chip never answers at position 7
    hang_pos = 7;
    run_cfg(1'b0, cyc);
    check("tmo_flag", int'(err_timeout), 1);
    check("tmo_first", int'(first_err_pos), 7);
    check("tmo_max_rpos", mon_max_rpos, 7);
    check("tmo_acks", mon_acks, 7);
    check("tmo_mismatch", int'(mismatch_cnt), 0);
    hang_pos = -1;
`endif

    // Abort during the write pulse at position 12
    clear_mon();
    start = 1'b1;
    @(posedge clk_50M); #1;
    start = 1'b0;
    cyc = 1;
    while (!(cap_wena && cap_position == 5'd12) && cyc < C_BOUND) begin
      @(posedge clk_50M); #1;
      cyc++;
    end
    check("abort_reached_pos12", int'(cap_wena && cap_position == 5'd12), 1);
    abort = 1'b1;
    @(posedge clk_50M); #1;
    abort = 1'b0;
    check("abort_wena", int'(cap_wena), 0);
    check("abort_rstn", int'(cap_rstn), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pos", int'(cap_position), 0);
    repeat (3) @(posedge clk_50M);
    #1;
    check("abort_stays_idle", int'(busy), 0);
    run_cfg(1'b0, cyc);
    check("rerun_cycles", cyc, C_RUN_CYC);
    check("rerun_rst_low", mon_rst_low, RST_CYCLES);
    check("rerun_pulses", mon_pulses, N_POS);

    // Table write and start while busy are ignored
    run_cfg(1'b1, cyc);
    check("busy_no_restart", cyc, C_RUN_CYC);
    check("busy_we_coef3", int'(mon_coef[3]), 3);
    run_cfg(1'b0, cyc);
    check("busy_we_run2_coef3", int'(mon_coef[3]), 3);
    check("busy_we_mismatch", int'(mismatch_cnt), 0);

    // Idle table write takes effect
    tbl_we = 1'b1; tbl_addr = 5'd3; tbl_data = 3'd6; m_tbl[3] = 3'd6;
    @(posedge clk_50M); #1;
    tbl_we = 1'b0;
    run_cfg(1'b0, cyc);
    check("idle_we_coef3", int'(mon_coef[3]), 6);
    check("idle_we_mismatch", int'(mismatch_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
